// File: rtl/riscv_pkg.sv
// Shared core constants: access-size encodings and data-side MMIO register offsets.
package riscv_pkg;

  localparam logic [2:0] ACC_BYTE = 3'b001;
  localparam logic [2:0] ACC_HALF = 3'b010;
  localparam logic [2:0] ACC_WORD = 3'b100;

  localparam logic [3:0] TOHOST_OFF   = 4'h0;
  localparam logic [3:0] CYCLE_LO_OFF = 4'h4;
  localparam logic [3:0] CYCLE_HI_OFF = 4'h8;

  // Byte-lane mask of an access before lane shifting; zero for a non-one-hot size.
  function automatic logic [3:0] size_lanes(input logic [2:0] size);
    case (size)
      ACC_BYTE: size_lanes = 4'b0001;
      ACC_HALF: size_lanes = 4'b0011;
      ACC_WORD: size_lanes = 4'b1111;
      default:  size_lanes = 4'b0000;
    endcase
  endfunction

  // Expands a 4-bit lane mask to a 32-bit bit mask.
  function automatic logic [31:0] lane_bits(input logic [3:0] lanes);
    lane_bits = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Data RAM: combinational read, byte-enabled synchronous write, contents not reset.
module dmem_ram #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW         = $clog2(DEPTH_WORDS),
  localparam int unsigned NB         = XLEN / 8
) (
  input  logic            clk,
  input  logic [AW-1:0]   addr,
  input  logic [NB-1:0]   be,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(NB); b++) begin
      if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_resp.sv
// Execute-stage data memory responder: RAM, tohost/cycle MMIO and sticky error flag.
// Build option: DMEM_MISALIGN_SPLIT_EN splits misaligned in-RAM accesses into two beats.
module dmem_resp
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0] RAM_BASE    = 32'h0001_0000,
  parameter logic [XLEN-1:0] MMIO_BASE   = 32'h0002_0000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            adr_v_i,
  input  logic [XLEN-1:0] adr_i,
  input  logic            is_store_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [2:0]      access_size_i,
  output logic [XLEN-1:0] load_data_o,
  output logic            err_o,
  output logic            halt_o,
`ifdef DMEM_MISALIGN_SPLIT_EN
  output logic            stall_o,
`endif
  output logic [XLEN-1:0] tohost_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [XLEN-1:0] RAM_BYTES = XLEN'(4 * DEPTH_WORDS);
`ifdef DMEM_MISALIGN_SPLIT_EN
  localparam int unsigned WIN = 2;
`else
  localparam int unsigned WIN = 1;
`endif

  logic [XLEN-1:0]     ram_off, mmio_off, mmio_rdata, ram_rdata, ram_wdata;
  logic [AW-1:0]       ram_addr;
  logic [3:0]          ram_be, lanes;
  logic [4*WIN-1:0]    be_sh;
  logic [WIN*XLEN-1:0] wdata_sh;
  logic [4:0]          bit_sh;
  logic                size_ok, aligned, in_ram, in_mmio, ram_ok, mmio_ok, legal, split;
  logic [63:0]         cycle;

  // Address decode and legality
  assign ram_off  = adr_i - RAM_BASE;
  assign mmio_off = adr_i - MMIO_BASE;
  assign in_ram   = ram_off < RAM_BYTES;
  assign in_mmio  = mmio_off < XLEN'(16);
  assign lanes    = size_lanes(access_size_i);
  assign size_ok  = |lanes;
  assign aligned  = (access_size_i == ACC_BYTE)
                 || (access_size_i == ACC_HALF && !adr_i[0])
                 || (access_size_i == ACC_WORD && adr_i[1:0] == 2'b00);
  assign ram_ok   = size_ok && aligned && in_ram;
  assign mmio_ok  = access_size_i == ACC_WORD && adr_i[1:0] == 2'b00 && in_mmio;
  assign legal    = ram_ok || mmio_ok;

  assign bit_sh   = {adr_i[1:0], 3'b000};
  assign be_sh    = (4*WIN)'(lanes) << adr_i[1:0];
  assign wdata_sh = (WIN*XLEN)'(store_data_i) << bit_sh;

  always_comb begin
    case (mmio_off[3:0])
      TOHOST_OFF:   mmio_rdata = tohost_o;
      CYCLE_LO_OFF: mmio_rdata = cycle[31:0];
      CYCLE_HI_OFF: mmio_rdata = cycle[63:32];
      default:      mmio_rdata = '0;
    endcase
  end

`ifdef DMEM_MISALIGN_SPLIT_EN
  typedef enum logic {S_IDLE, S_SECOND} split_state_t;
  split_state_t    state;
  logic [XLEN-1:0] lo_q;

  // Misaligned half/word whose last byte is still inside RAM
  assign split = adr_v_i && size_ok && !aligned && access_size_i != ACC_BYTE && in_ram
              && (ram_off + XLEN'(access_size_i == ACC_WORD ? 3 : 1)) < RAM_BYTES;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      lo_q  <= '0;
    end else if (state == S_IDLE && split) begin
      state <= S_SECOND;
      lo_q  <= ram_rdata;
    end else begin
      state <= S_IDLE;
    end
  end
`else
  assign split = 1'b0;
`endif

  // RAM port steering and load data return
  always_comb begin
    ram_addr    = ram_off[AW+1:2];
    ram_be      = '0;
    ram_wdata   = wdata_sh[XLEN-1:0];
    load_data_o = '0;
`ifdef DMEM_MISALIGN_SPLIT_EN
    stall_o     = 1'b0;
`endif
    if (adr_v_i && legal) begin
      if (is_store_i) begin
        if (ram_ok) ram_be = be_sh[3:0];
      end else if (ram_ok) begin
        load_data_o = (ram_rdata >> bit_sh) & lane_bits(lanes);
      end else begin
        load_data_o = mmio_rdata;
      end
    end
`ifdef DMEM_MISALIGN_SPLIT_EN
    if (split) begin
      if (state == S_IDLE) begin
        stall_o = 1'b1;
        if (is_store_i) ram_be = be_sh[3:0];
      end else begin
        ram_addr  = ram_off[AW+1:2] + AW'(1);
        ram_wdata = wdata_sh[2*XLEN-1:XLEN];
        if (is_store_i) ram_be = be_sh[7:4];
        else load_data_o = XLEN'({ram_rdata, lo_q} >> bit_sh) & lane_bits(lanes);
      end
    end
`endif
  end

  dmem_ram #(
    .XLEN        (XLEN),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .be    (ram_be),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Sticky flags, tohost register and free-running cycle counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_o    <= 1'b0;
      halt_o   <= 1'b0;
      tohost_o <= '0;
      cycle    <= '0;
    end else begin
      cycle <= cycle + 64'(1);
      if (adr_v_i && !legal && !split) err_o <= 1'b1;
      if (adr_v_i && is_store_i && mmio_ok && mmio_off[3:0] == TOHOST_OFF) begin
        tohost_o <= store_data_i;
        if (store_data_i != '0) halt_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: directed vector table, corner sequences, random vs byte-level model.
module tb_dmem_resp;
  import riscv_pkg::*;

  localparam logic [31:0] RB = 32'h0001_0000;
  localparam logic [31:0] MB = 32'h0002_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        adr_v = 1'b0;
  logic [31:0] adr = '0;
  logic        is_store = 1'b0;
  logic [31:0] store_data = '0;
  logic [2:0]  access_size = ACC_WORD;
  logic [31:0] load_data;
  logic        err, halt;
  logic [31:0] tohost;

  always #5 clk = ~clk;

  dmem_resp dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .adr_v_i       (adr_v),
    .adr_i         (adr),
    .is_store_i    (is_store),
    .store_data_i  (store_data),
    .access_size_i (access_size),
    .load_data_o   (load_data),
    .err_o         (err),
    .halt_o        (halt),
    .tohost_o      (tohost)
  );

  int checks = 0;
  int failures = 0;

  // Reference state: byte-addressed RAM image, MMIO registers, edges since reset release
  logic [7:0]      mem_m [4096];
  logic [31:0]     tohost_m = '0;
  bit              halt_m = 1'b0;
  bit              err_m = 1'b0;
  longint unsigned edges = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) edges <= 0;
    else          edges <= edges + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] sz);
    if (sz == 3'b001) return 1;
    if (sz == 3'b010) return 2;
    if (sz == 3'b100) return 4;
    return 0;
  endfunction

  function automatic bit in_ram_m(input logic [31:0] a);
    return a >= RB && a < RB + 32'd4096;
  endfunction

  function automatic bit legal_m(input logic [31:0] a, input logic [2:0] sz);
    int n = nbytes(sz);
    if (n == 0) return 1'b0;
    if (a % n != 0) return 1'b0;
    if (in_ram_m(a)) return 1'b1;
    if (a >= MB && a < MB + 32'd16) return n == 4;
    return 1'b0;
  endfunction

  function automatic logic [31:0] load_m(input bit v, input logic [31:0] a, input bit st,
                                         input logic [2:0] sz);
    logic [31:0] r = '0;
    int n = nbytes(sz);
    if (!v || st || !legal_m(a, sz)) return '0;
    if (in_ram_m(a)) begin
      for (int i = 0; i < n; i++) r = r | (32'(mem_m[a - RB + i]) << (8 * i));
      return r;
    end
    case (a - MB)
      32'd0:   return tohost_m;
      32'd4:   return edges[31:0];
      32'd8:   return edges[63:32];
      default: return '0;
    endcase
  endfunction

  // One request cycle: drive at negedge, check combinational load, commit model at the edge, check flags
  task automatic acc(input bit v, input logic [31:0] a, input bit st, input logic [31:0] d,
                     input logic [2:0] sz, input string nm, input bit use_exp,
                     input logic [31:0] exp_in);
    logic [31:0] exp;
    @(negedge clk);
    adr_v = v; adr = a; is_store = st; store_data = d; access_size = sz;
    #1;
    exp = use_exp ? exp_in : load_m(v, a, st, sz);
    chk(nm, 64'(load_data), 64'(exp));
    @(posedge clk);
    if (v) begin
      if (!legal_m(a, sz)) err_m = 1'b1;
      else if (st && in_ram_m(a)) begin
        for (int i = 0; i < nbytes(sz); i++) mem_m[a - RB + i] = d[8*i +: 8];
      end else if (st && a == MB) begin
        tohost_m = d;
        if (d != 0) halt_m = 1'b1;
      end
    end
    #1;
    chk({nm, "_flags"}, {31'd0, err, halt, tohost}, {31'd0, err_m, halt_m, tohost_m});
  endtask

  task automatic model_reset();
    err_m = 1'b0; halt_m = 1'b0; tohost_m = '0;
  endtask

  typedef struct {
    bit          v;
    logic [31:0] a;
    bit          st;
    logic [31:0] d;
    logic [2:0]  sz;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [31:0] ra, rd;
    logic [2:0]  rs;
    int          sel;

    tbl.push_back('{1, 32'h0001_0000, 1, 32'hDEAD_BEEF, ACC_WORD, 32'h0});
    tbl.push_back('{1, 32'h0001_0000, 0, 32'h0,         ACC_WORD, 32'hDEAD_BEEF});
    tbl.push_back('{1, 32'h0001_0004, 1, 32'h1122_3344, ACC_WORD, 32'h0});
    tbl.push_back('{1, 32'h0001_0005, 1, 32'h0000_00AA, ACC_BYTE, 32'h0});
    tbl.push_back('{1, 32'h0001_0004, 0, 32'h0,         ACC_WORD, 32'h1122_AA44});
    tbl.push_back('{1, 32'h0001_0005, 0, 32'h0,         ACC_BYTE, 32'h0000_00AA});
    tbl.push_back('{1, 32'h0001_0006, 0, 32'h0,         ACC_HALF, 32'h0000_1122});
    tbl.push_back('{1, 32'h0001_0002, 1, 32'hFFFF_5566, ACC_HALF, 32'h0});
    tbl.push_back('{1, 32'h0001_0000, 0, 32'h0,         ACC_WORD, 32'h5566_BEEF});
    tbl.push_back('{1, 32'h0001_0003, 0, 32'h0,         ACC_BYTE, 32'h0000_0055});
    tbl.push_back('{0, 32'h0001_0000, 0, 32'h0,         ACC_WORD, 32'h0});
    tbl.push_back('{1, 32'h0001_0FFC, 1, 32'hCAFE_F00D, ACC_WORD, 32'h0});
    tbl.push_back('{1, 32'h0001_0FFF, 0, 32'h0,         ACC_BYTE, 32'h0000_00CA});

    // Reset state
    #12;
    chk("reset_flags", {31'd0, err, halt, tohost}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (tbl[i])
      acc(tbl[i].v, tbl[i].a, tbl[i].st, tbl[i].d, tbl[i].sz, $sformatf("vec%0d", i), 1'b1, tbl[i].exp);

    // Misaligned half load: returns 0, sticky error, RAM untouched
    acc(1, 32'h0001_0003, 0, 0, ACC_HALF, "misalign_half", 1'b1, 32'h0);
    chk("err_after_misalign", 64'(err), 64'd1);
    acc(1, 32'h0001_0002, 1, 32'hFFFF_FFFF, ACC_WORD, "misalign_store", 1'b1, 32'h0);
    acc(1, 32'h0001_0004, 0, 0, 3'b011, "bad_size", 1'b1, 32'h0);
    for (int i = 0; i < 10; i++)
      acc(1, 32'h0001_0000, 0, 0, ACC_WORD, "legal_after_err", 1'b1, 32'h5566_BEEF);
    chk("err_sticky", 64'(err), 64'd1);

    // tohost: non-zero sets halt, zero only updates the value
    acc(1, MB, 1, 32'h1, ACC_WORD, "tohost_wr1", 1'b1, 32'h0);
    chk("halt_set", {31'd0, halt, tohost}, {31'd0, 1'b1, 32'h1});
    acc(1, MB, 1, 32'h0, ACC_WORD, "tohost_wr0", 1'b1, 32'h0);
    chk("halt_sticky", {31'd0, halt, tohost}, {31'd0, 1'b1, 32'h0});
    acc(1, 32'h0001_0004, 0, 0, ACC_WORD, "access_while_halt", 1'b1, 32'h1122_AA44);

    // Asynchronous reset mid-request clears flags immediately
    @(negedge clk);
    adr_v = 1'b1; adr = 32'h0001_0008; is_store = 1'b1; store_data = 32'h7777_7777;
    access_size = ACC_WORD;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset_flags", {31'd0, err, halt, tohost}, 64'd0);
    adr_v = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Counter restarted: read cycle_lo when 100 edges have elapsed since release
    for (int n = 0; n < 200 && edges != 99; n++) @(negedge clk);
    chk("edge_sync", 64'(edges), 64'd99);
    acc(1, MB + 32'h4, 0, 0, ACC_WORD, "cycle_lo_100", 1'b1, 32'd100);
    acc(1, MB + 32'h8, 0, 0, ACC_WORD, "cycle_hi", 1'b1, 32'd0);
    acc(1, 32'h0001_0000, 0, 0, ACC_WORD, "ram_kept", 1'b1, 32'h5566_BEEF);
    acc(1, MB + 32'h4, 1, 32'h1234, ACC_WORD, "cycle_ro_store", 1'b1, 32'h0);
    chk("ro_store_no_err", 64'(err), 64'd0);
    acc(1, MB + 32'h4, 0, 0, ACC_WORD, "cycle_lo_model", 1'b0, 32'h0);
    acc(1, MB + 32'hC, 1, 32'h55, ACC_WORD, "reserved_wr", 1'b1, 32'h0);
    acc(1, MB + 32'hC, 0, 0, ACC_WORD, "reserved_rd", 1'b1, 32'h0);
    acc(1, MB + 32'h4, 0, 0, ACC_HALF, "mmio_half", 1'b1, 32'h0);
    acc(1, 32'h0003_0000, 0, 0, ACC_WORD, "unmapped", 1'b1, 32'h0);
    chk("unmapped_err", 64'(err), 64'd1);

    // Random phase over a fully initialised 64-byte RAM window
    for (int w = 0; w < 16; w++)
      acc(1, RB + 32'(4 * w), 1, $urandom, ACC_WORD, "rnd_init", 1'b0, 32'h0);
    for (int i = 0; i < 400; i++) begin
      rs = 3'b000;
      case ($urandom_range(0, 9))
        0: rs = 3'b011;
        1: rs = 3'b110;
        2, 3, 4: rs = ACC_BYTE;
        5, 6, 7: rs = ACC_HALF;
        default: rs = ACC_WORD;
      endcase
      sel = $urandom_range(0, 9);
      if (sel < 7)      ra = RB + 32'($urandom_range(0, 63));
      else if (sel < 9) ra = MB + 32'($urandom_range(0, 15));
      else              ra = 32'h0004_0000 + 32'($urandom_range(0, 255));
      rd = (sel >= 7 && $urandom_range(0, 3) != 0) ? 32'h0 : $urandom;
      acc($urandom_range(0, 9) != 0, ra, $urandom_range(0, 1) == 1, rd, rs, "rnd", 1'b0, 32'h0);
    end

    @(negedge clk);
    adr_v = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
